// File: rtl/usb_rx_depacketizer_pkg.sv
// Shared types and constants for the USB receive depacketizer.
//   rx_state_e : receive FSM states
//   SYNC_PAT   : decoded SYNC byte (seven 0s then a 1, LSB first)
//   ERR_*      : err_code values, first error of a packet wins
//   PID_*      : PID[3:0] values of the common token/data/handshake packets
//   pid_ok()   : PID check, upper nibble must be the complement of the lower
package usb_rx_depacketizer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_ERR,
    ST_EOPW
  } rx_state_e;

  localparam logic [7:0] SYNC_PAT  = 8'h80;

  // After this many consecutive decoded 1s the transmitter inserts a 0
  localparam int         STUFF_RUN = 6;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_SYNC  = 3'd1;
  localparam logic [2:0] ERR_PID   = 3'd2;
  localparam logic [2:0] ERR_STUFF = 3'd3;
  localparam logic [2:0] ERR_ALIGN = 3'd4;
  localparam logic [2:0] ERR_OVF   = 3'd5;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  function automatic logic pid_ok(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction

endpackage

// File: rtl/usb_rx_depacketizer_if.sv
// Line-side inputs and host-side outputs of the receive depacketizer.
//   slave  : the depacketizer (consumes line_*, drives decoded results)
//   master : the line decoder / host side (drives line_*, observes results)
// CNT_W must equal $clog2(MAX_BYTES+2) of the attached depacketizer.
interface usb_rx_depacketizer_if #(
  parameter int CNT_W = 7
);
  logic             line_bit;
  logic             line_valid;
  logic             line_eop;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic [3:0]       pid;
  logic             pid_valid;
  logic             pkt_end;
  logic             pkt_err;
  logic [2:0]       err_code;
  logic [CNT_W-1:0] byte_cnt;
  logic             busy;

  modport slave (
    input  line_bit, line_valid, line_eop,
    output byte_out, byte_valid, pid, pid_valid, pkt_end, pkt_err,
           err_code, byte_cnt, busy
  );

  modport master (
    output line_bit, line_valid, line_eop,
    input  byte_out, byte_valid, pid, pid_valid, pkt_end, pkt_err,
           err_code, byte_cnt, busy
  );
endinterface

// File: rtl/usb_rx_depacketizer_nrzi_unstuff.sv
// NRZI decoder and bit unstuffer.
//   clk, rst_L   : clock, async active-low reset
//   line_bit_i   : raw line level (1=J)
//   bit_en_i     : line bit is consumed this cycle (valid and not EOP)
//   flush_i      : return to idle line state (J, no run of 1s)
//   dbit_o       : decoded bit (no transition = 1)
//   dvalid_o     : dbit_o is a real data bit (not a stuff bit)
//   stuff_err_o  : a 1 arrived where a stuff 0 was required
// Outputs are combinational from the current line bit.
module usb_nrzi_unstuff
  import usb_rx_depacketizer_pkg::*;
(
  input  logic clk,
  input  logic rst_L,
  input  logic line_bit_i,
  input  logic bit_en_i,
  input  logic flush_i,
  output logic dbit_o,
  output logic dvalid_o,
  output logic stuff_err_o
);

  logic       prev_q, prev_d;
  logic [2:0] ones_q, ones_d;
  logic       stuff_slot;

  always_comb begin
    dbit_o      = (line_bit_i == prev_q);
    stuff_slot  = (ones_q == 3'(STUFF_RUN));
    dvalid_o    = bit_en_i && !stuff_slot;
    stuff_err_o = bit_en_i && stuff_slot && dbit_o;

    prev_d = prev_q;
    ones_d = ones_q;
    if (flush_i) begin
      prev_d = 1'b1;
      ones_d = '0;
    end else if (bit_en_i) begin
      // Level tracking includes stuff bits; the run restarts after a stuff slot
      prev_d = line_bit_i;
      if (stuff_slot || !dbit_o) ones_d = '0;
      else                       ones_d = ones_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      prev_q <= 1'b1;
      ones_q <= '0;
    end else begin
      prev_q <= prev_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/usb_rx_depacketizer.sv
// USB receive depacketizer: NRZI decode, unstuff, SYNC/PID check, byte output.
//   clk, rst_L : clock, async active-low reset
//   rx (slave) : line_bit/line_valid/line_eop in;
//                byte_out/byte_valid, pid/pid_valid, pkt_end/pkt_err,
//                err_code, byte_cnt, busy out (all registered)
// MAX_BYTES bounds data bytes after the PID; one more is an overflow.
module usb_rx_depacketizer
  import usb_rx_depacketizer_pkg::*;
#(
  parameter int MAX_BYTES = 66
) (
  input  logic                  clk,
  input  logic                  rst_L,
  usb_rx_depacketizer_if.slave  rx
);

  localparam int CNT_W = $clog2(MAX_BYTES + 2);

  rx_state_e        state_q, state_d;
  logic [7:0]       sr_q, sr_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_valid_q, byte_valid_d;
  logic [3:0]       pid_q, pid_d;
  logic             pid_valid_q, pid_valid_d;
  logic             pkt_end_q, pkt_end_d;
  logic             pkt_err_q, pkt_err_d;
  logic [2:0]       err_code_q, err_code_d;
  logic             busy_q, busy_d;
  logic             rpt_q, rpt_d;   // pkt_end already issued (overflow)

  logic       bit_en, flush;
  logic       dbit, dvalid, stuff_err;
  logic [7:0] sr_next;

  // EOP outranks a coincident line bit
  assign bit_en = rx.line_valid && !rx.line_eop;
  assign flush  = (state_q == ST_EOPW) && !rx.line_eop;

  usb_nrzi_unstuff u_nrzi (
    .clk         (clk),
    .rst_L       (rst_L),
    .line_bit_i  (rx.line_bit),
    .bit_en_i    (bit_en),
    .flush_i     (flush),
    .dbit_o      (dbit),
    .dvalid_o    (dvalid),
    .stuff_err_o (stuff_err)
  );

  assign sr_next = {dbit, sr_q[7:1]};

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_idx_d    = bit_idx_q;
    byte_cnt_d   = byte_cnt_q;
    byte_out_d   = byte_out_q;
    pid_d        = pid_q;
    err_code_d   = err_code_q;
    busy_d       = busy_q;
    rpt_d        = rpt_q;
    byte_valid_d = 1'b0;
    pid_valid_d  = 1'b0;
    pkt_end_d    = 1'b0;
    pkt_err_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The first bit seen is SYNC bit 0
        if (dvalid) begin
          state_d    = ST_SYNC;
          sr_d       = sr_next;
          bit_idx_d  = 3'd1;
          busy_d     = 1'b1;
          err_code_d = ERR_NONE;
          byte_cnt_d = '0;
          pid_d      = '0;
          rpt_d      = 1'b0;
        end
      end

      ST_SYNC, ST_PID, ST_DATA: begin
        if (rx.line_eop) begin
          state_d   = ST_EOPW;
          pkt_end_d = 1'b1;
          if (state_q == ST_SYNC) begin
            pkt_err_d  = 1'b1;
            err_code_d = ERR_SYNC;
          end else if (state_q == ST_PID) begin
            pkt_err_d  = 1'b1;
            err_code_d = ERR_PID;
          end else if (bit_idx_q != 3'd0) begin
            // Partial byte is dropped
            pkt_err_d  = 1'b1;
            err_code_d = ERR_ALIGN;
          end
        end else if (stuff_err) begin
          state_d    = ST_ERR;
          err_code_d = ERR_STUFF;
        end else if (dvalid) begin
          sr_d      = sr_next;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            if (state_q == ST_SYNC) begin
              if (sr_next == SYNC_PAT) begin
                state_d = ST_PID;
              end else begin
                state_d    = ST_ERR;
                err_code_d = ERR_SYNC;
              end
            end else if (state_q == ST_PID) begin
              if (pid_ok(sr_next)) begin
                state_d     = ST_DATA;
                pid_d       = sr_next[3:0];
                pid_valid_d = 1'b1;
              end else begin
                state_d    = ST_ERR;
                err_code_d = ERR_PID;
              end
            end else if (byte_cnt_q == CNT_W'(MAX_BYTES)) begin
              // Overflow is reported immediately, not at EOP
              state_d    = ST_ERR;
              pkt_end_d  = 1'b1;
              pkt_err_d  = 1'b1;
              err_code_d = ERR_OVF;
              rpt_d      = 1'b1;
            end else begin
              byte_out_d   = sr_next;
              byte_valid_d = 1'b1;
              byte_cnt_d   = byte_cnt_q + CNT_W'(1);
            end
          end
        end
      end

      ST_ERR: begin
        if (rx.line_eop) begin
          state_d = ST_EOPW;
          if (!rpt_q) begin
            pkt_end_d = 1'b1;
            pkt_err_d = 1'b1;
          end
        end
      end

      ST_EOPW: begin
        if (!rx.line_eop) begin
          state_d   = ST_IDLE;
          bit_idx_d = '0;
          busy_d    = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q      <= ST_IDLE;
      sr_q         <= '0;
      bit_idx_q    <= '0;
      byte_cnt_q   <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      pid_q        <= '0;
      pid_valid_q  <= 1'b0;
      pkt_end_q    <= 1'b0;
      pkt_err_q    <= 1'b0;
      err_code_q   <= ERR_NONE;
      busy_q       <= 1'b0;
      rpt_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_idx_q    <= bit_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      pid_q        <= pid_d;
      pid_valid_q  <= pid_valid_d;
      pkt_end_q    <= pkt_end_d;
      pkt_err_q    <= pkt_err_d;
      err_code_q   <= err_code_d;
      busy_q       <= busy_d;
      rpt_q        <= rpt_d;
    end
  end

  assign rx.byte_out   = byte_out_q;
  assign rx.byte_valid = byte_valid_q;
  assign rx.pid        = pid_q;
  assign rx.pid_valid  = pid_valid_q;
  assign rx.pkt_end    = pkt_end_q;
  assign rx.pkt_err    = pkt_err_q;
  assign rx.err_code   = err_code_q;
  assign rx.byte_cnt   = byte_cnt_q;
  assign rx.busy       = busy_q;

endmodule
